// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if: serial input and parallel result signals of the UART receiver.
// master is the receiver side, slave the consumer side.
interface uart_rx_os16_if #(parameter int DATA_BITS = 8);
  logic rx;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_done;
  logic frame_err;
  logic parity_err;
  logic busy;
  modport master (input rx, output rx_data, rx_done, frame_err, parity_err, busy);
  modport slave (output rx, input rx_data, rx_done, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling UART receiver with 2-of-3 mid-bit voting, false-start rejection and framing errors.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_os16 #(
  parameter int CLKS_PER_TICK = 54,
  parameter int DATA_BITS = 8
) (
  input logic clk,
  input logic rst,
  uart_rx_os16_if.master bus
);
  localparam int TW = $clog2(CLKS_PER_TICK);
  localparam int IW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] samp_q, samp_d;
  logic [1:0] vote_q, vote_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d, armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  logic rx_s, tick, mid, wrap, maj;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      tick_q <= '0;
      samp_q <= '0;
      vote_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      armed_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      tick_q <= tick_d;
      samp_q <= samp_d;
      vote_q <= vote_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end

  always_comb begin
    rx_s = sync_q[1];
    tick = tick_q == TW'(CLKS_PER_TICK - 1);
    mid = tick && samp_q == 4'd9;
    wrap = tick && samp_q == 4'd15;
    maj = (vote_q[0] & vote_q[1]) | (rx_s & (vote_q[0] | vote_q[1]));
    sync_d = {sync_q[0], bus.rx};
    state_d = state_q;
    tick_d = tick ? '0 : tick_q + 1'b1;
    samp_d = samp_q + {3'd0, tick};
    vote_d = vote_q;
    if (tick && samp_q == 4'd7) vote_d[0] = rx_s;
    if (tick && samp_q == 4'd8) vote_d[1] = rx_s;
    idx_d = idx_q;
    shift_d = shift_q;
    data_d = data_q;
    armed_d = armed_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        tick_d = '0;
        samp_d = '0;
        idx_d = '0;
        if (rx_s) armed_d = 1'b1;
        else if (armed_q) state_d = START;
      end
      START:
        if (mid && maj) state_d = IDLE;
        else if (wrap) state_d = DATA;
      DATA: begin
        if (mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          idx_d = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == IW'(DATA_BITS - 1)) state_d = PARITY;
`else
          if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) par_d = maj;
        if (wrap) state_d = STOP;
      end
`endif
      STOP:
        // Leave at mid-stop so a start bit with zero idle time is still caught.
        if (mid) begin
          state_d = IDLE;
          if (!maj) begin
            ferr_d = 1'b1;
            armed_d = 1'b0;
          end
`ifdef UART_RX_PARITY_EN
          else if (^shift_q ^ par_q) perr_d = 1'b1;
`endif
          else begin
            done_d = 1'b1;
            data_d = shift_q;
          end
        end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = state_q != IDLE;
    bus.rx_data = data_q;
    bus.rx_done = done_q;
    bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    bus.parity_err = perr_q;
`else
    bus.parity_err = 1'b0;
`endif
  end
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: table-driven, hand-sequenced and randomized self-checking bench for uart_rx_os16.
// Expected results come from frame-level rules: good stop -> byte delivered, low stop -> frame error, byte kept.
module tb_uart_rx_os16;
  localparam int CPT = 4;
  localparam int BIT = 16 * CPT;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passed = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] d;
    bit ok;
    int per;
    int idle;
    int e_done;
    int e_ferr;
    logic [7:0] e_data;
  } vec_t;
  vec_t tbl[7];

  uart_rx_os16_if #(.DATA_BITS(8)) bus();
  uart_rx_os16 #(.CLKS_PER_TICK(CPT), .DATA_BITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_data"}, int'(bus.rx_data), 0);
    check({nm, "_done"}, int'(bus.rx_done), 0);
    check({nm, "_ferr"}, int'(bus.frame_err), 0);
    check({nm, "_perr"}, int'(bus.parity_err), 0);
    check({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.rx_done) n_done++;
    if (bus.frame_err) n_ferr++;
    if (bus.parity_err) n_perr++;
    if (bus.rx_done || bus.frame_err || bus.parity_err) begin
      check("pulse_excl", int'(bus.rx_done) + int'(bus.frame_err) + int'(bus.parity_err), 1);
      check("pulse_width", int'(prev_pulse), 0);
    end
    prev_pulse = bus.rx_done || bus.frame_err || bus.parity_err;
  end

  task automatic send(input logic [7:0] d, input bit ok, input bit pbad, input int per,
                      input int flip_bit, input int rst_at);
    logic [10:0] bits;
    int nb;
`ifdef UART_RX_PARITY_EN
    nb = 11;
    bits = {ok, ^d ^ pbad, d, 1'b0};
`else
    nb = 10;
    bits = {pbad, ok, d, 1'b0};
`endif
    for (int c = 0; c < nb * per; c++) begin
      @(negedge clk);
      bus.rx = bits[c / per] ^ (c / per == flip_bit && c % per >= 35 && c % per < 39);
      rst = !(rst_at >= 0 && c >= rst_at && c < rst_at + 3);
      if (rst_at >= 0 && c == rst_at + 1) begin
        #1;
        chk_zero("rst_mid");
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx = 1'b1;
    end
  endtask

  task automatic frame(input string nm, input logic [7:0] d, input bit ok, input bit pbad,
                       input int per, input int gap, input int e_done, input int e_ferr,
                       input int e_perr, input logic [7:0] e_data);
    int d0 = n_done;
    int f0 = n_ferr;
    int p0 = n_perr;
    send(d, ok, pbad, per, -1, -1);
    idle(gap);
    check({nm, "_done"}, n_done - d0, e_done);
    check({nm, "_ferr"}, n_ferr - f0, e_ferr);
    check({nm, "_perr"}, n_perr - p0, e_perr);
    check({nm, "_data"}, int'(bus.rx_data), int'(e_data));
    check({nm, "_busy"}, int'(bus.busy), 0);
    if (e_done != 0) last_good = e_data;
  endtask

  initial begin
    int d0, f0, lo_at;
    bit seen;
    bus.rx = 1'b1;
    tbl[0] = '{8'h55, 1'b1, BIT, 10, 1, 0, 8'h55};
    tbl[1] = '{8'hA3, 1'b1, BIT, 0, 1, 0, 8'hA3};
    tbl[2] = '{8'h0F, 1'b1, BIT, 10, 1, 0, 8'h0F};
    tbl[3] = '{8'hC5, 1'b1, 62, 5, 1, 0, 8'hC5};
    tbl[4] = '{8'hC5, 1'b1, 66, 5, 1, 0, 8'hC5};
    tbl[5] = '{8'h3C, 1'b0, BIT, 10, 0, 1, 8'hC5};
    tbl[6] = '{8'h81, 1'b1, BIT, 10, 1, 0, 8'h81};
    repeat (3) @(negedge clk);
    chk_zero("in_rst");
    rst = 1'b1;
    idle(10);
    chk_zero("post_rst");

    for (int i = 0; i < 7; i++)
      frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].ok, 1'b0, tbl[i].per, tbl[i].idle,
            tbl[i].e_done, tbl[i].e_ferr, 0, tbl[i].e_data);

    seen = 1'b0;
    lo_at = -1;
    d0 = n_done;
    f0 = n_ferr;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.rx = i >= 20;
      #1;
      if (bus.busy) seen = 1'b1;
      else if (seen && lo_at < 0) lo_at = i;
    end
    check("glitch_busy_seen", int'(seen), 1);
    check("glitch_idle_by_45", int'(lo_at >= 0 && lo_at <= 45), 1);
    check("glitch_done", n_done - d0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    frame("pre_brk", 8'h5A, 1'b1, 1'b0, BIT, 10, 1, 0, 0, 8'h5A);
    d0 = n_done;
    f0 = n_ferr;
    send(8'h3C, 1'b0, 1'b0, BIT, -1, -1);
    repeat (2000) @(negedge clk);
    check("brk_ferr", n_ferr - f0, 1);
    check("brk_done", n_done - d0, 0);
    check("brk_data", int'(bus.rx_data), int'(last_good));
    check("brk_busy", int'(bus.busy), 0);
    idle(20);
    frame("brk_next", 8'h81, 1'b1, 1'b0, BIT, 10, 1, 0, 0, 8'h81);

    d0 = n_done;
    send(8'h00, 1'b1, 1'b0, BIT, 4, -1);
    idle(10);
    check("vote_done", n_done - d0, 1);
    check("vote_data", int'(bus.rx_data), 0);
    last_good = 8'h00;

    frame("pre_abort", 8'h99, 1'b1, 1'b0, BIT, 10, 1, 0, 0, 8'h99);
    d0 = n_done;
    f0 = n_ferr;
    send(8'hF0, 1'b1, 1'b1, BIT, -1, 5 * BIT + 20);
    idle(20);
    check("abort_done", n_done - d0, 0);
    check("abort_ferr", n_ferr - f0, 0);
    check("abort_data", int'(bus.rx_data), 0);
    last_good = 8'h00;
    frame("post_abort", 8'h7E, 1'b1, 1'b0, BIT, 10, 1, 0, 0, 8'h7E);
`ifdef UART_RX_PARITY_EN
    frame("par_bad", 8'h7E, 1'b1, 1'b1, BIT, 10, 0, 0, 1, 8'h7E);
    frame("par_next", 8'h24, 1'b1, 1'b0, BIT, 10, 1, 0, 0, 8'h24);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      bit ok;
      int per, gap;
      d = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      per = $urandom_range(62, 66);
      gap = ok ? $urandom_range(0, 12) : $urandom_range(4, 12);
      frame($sformatf("rnd%0d", i), d, ok, 1'b0, per, gap, int'(ok), int'(!ok), 0,
            ok ? d : last_good);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
